// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester ports and the data-memory port
// of the data-memory arbiter.
//   p0_* : pipeline MEM-stage requester (fixed priority)
//   p1_* : debug/loader requester (starvation-bounded)
//   mem_*: single-ported data memory, registered read data
// Modports:
//   slave  : arbiter side (takes requests and mem_rdata, drives grants,
//            read returns and memory controls)
//   master : environment side (requesters plus memory)
interface dmem_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p0_err;

  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;
  logic        p1_err;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the pipeline
// MEM stage (port 0, fixed priority) and the debug/loader port (port 1).
// An age counter forces port 1 through after MAX_WAIT consecutive denials.
// Read data (one-cycle memory latency) is routed back to the issuing port.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : dmem_arbiter_if.slave (requester ports and memory port)
// Parameters:
//   ADDR_W   : implemented word-address bits (memory holds 2^ADDR_W words)
//   MAX_WAIT : denied cycles before port 1 is forced through (1..15)
module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     bus
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_port_q, rd_port_d;
  logic       rd_oor_q, rd_oor_d;

  logic force_p1;
  logic p0_gnt, p1_gnt, any_gnt;
  logic p0_inr, p1_inr;
  logic sel_we, sel_inr;
  logic ret_valid;

  assign p0_inr = (bus.p0_addr[31:ADDR_W] == '0);
  assign p1_inr = (bus.p1_addr[31:ADDR_W] == '0);

  // Grants are combinational so the winner is accepted in its request cycle.
  assign force_p1 = bus.p1_req && (wait_cnt_q == MAX_WAIT_C);
  assign p1_gnt   = !rst && bus.p1_req && (force_p1 || !bus.p0_req);
  assign p0_gnt   = !rst && bus.p0_req && !p1_gnt;
  assign any_gnt  = p0_gnt || p1_gnt;

  assign sel_we  = p1_gnt ? bus.p1_we : bus.p0_we;
  assign sel_inr = p1_gnt ? p1_inr    : p0_inr;

  assign bus.p0_gnt    = p0_gnt;
  assign bus.p1_gnt    = p1_gnt;
  assign bus.mem_addr  = p1_gnt ? bus.p1_addr  : bus.p0_addr;
  assign bus.mem_wdata = p1_gnt ? bus.p1_wdata : bus.p0_wdata;
  // Out-of-range accesses are accepted but never reach the memory.
  assign bus.mem_write = any_gnt && sel_we && sel_inr;
  assign bus.mem_read  = any_gnt && !sel_we && sel_inr;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (rst || !bus.p1_req || p1_gnt)
      wait_cnt_d = '0;
    else if (wait_cnt_q != MAX_WAIT_C)
      wait_cnt_d = wait_cnt_q + 4'd1;
    rd_pend_d = any_gnt && !sel_we;
    rd_port_d = p1_gnt;
    rd_oor_d  = !sel_inr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_port_q  <= 1'b0;
      rd_oor_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_port_q  <= rd_port_d;
      rd_oor_q   <= rd_oor_d;
    end
  end

  // rd_pend_q is still set during a reset cycle that follows a read grant,
  // so the return is masked by rst directly. Only the owning port ever sees
  // memory data; the other port reads zero.
  assign ret_valid     = rd_pend_q && !rst;
  assign bus.p0_rvalid = ret_valid && !rd_port_q;
  assign bus.p1_rvalid = ret_valid && rd_port_q;
  assign bus.p0_rdata  = (bus.p0_rvalid && !rd_oor_q) ? bus.mem_rdata : '0;
  assign bus.p1_rdata  = (bus.p1_rvalid && !rd_oor_q) ? bus.mem_rdata : '0;
  assign bus.p0_err    = (p0_gnt && bus.p0_we && !p0_inr) || (bus.p0_rvalid && rd_oor_q);
  assign bus.p1_err    = (p1_gnt && bus.p1_we && !p1_inr) || (bus.p1_rvalid && rd_oor_q);

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] mem [0:1023];

  dmem_arbiter_if bus ();

  dmem_arbiter #(.ADDR_W(10), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Data memory model: write on the edge ending the grant, registered read.
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_ports();
    bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_addr = '0; bus.p1_wdata = '0;
  endtask

  task automatic p0_drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.p0_req = 1'b1; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
  endtask

  task automatic p1_drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.p1_req = 1'b1; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[1] = 32'h11; mem[2] = 32'h22; mem[3] = 32'h33;
    bus.mem_rdata = '0;

    // Reset held two cycles with both ports requesting.
    rst = 1'b1;
    idle_ports();
    p0_drive(1'b0, 32'd0, '0);
    p1_drive(1'b0, 32'd0, '0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_p0_gnt", 32'(bus.p0_gnt), 32'd0);
      chk("rst_p1_gnt", 32'(bus.p1_gnt), 32'd0);
      chk("rst_mem_rd", 32'(bus.mem_read), 32'd0);
      chk("rst_mem_wr", 32'(bus.mem_write), 32'd0);
      chk("rst_p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
      chk("rst_p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
      chk("rst_p0_err", 32'(bus.p0_err), 32'd0);
      chk("rst_p1_rdata", bus.p1_rdata, 32'd0);
      next_cycle();
    end
    chk("rst_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);

    // Release: port 0 read of addr 0 granted in the same cycle.
    rst = 1'b0;
    bus.p1_req = 1'b0;
    @(negedge clk);
    chk("rel_p0_gnt", 32'(bus.p0_gnt), 32'd1);
    chk("rel_mem_rd", 32'(bus.mem_read), 32'd1);

    // Port 0 write addr 5.
    next_cycle();
    p0_drive(1'b1, 32'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rel_p0_rvalid", 32'(bus.p0_rvalid), 32'd1);
    chk("rel_p0_rdata", bus.p0_rdata, 32'hA000_0000);
    chk("wr_p0_gnt", 32'(bus.p0_gnt), 32'd1);
    chk("wr_mem_wr", 32'(bus.mem_write), 32'd1);
    chk("wr_mem_addr", bus.mem_addr, 32'd5);
    chk("wr_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("wr_p0_err", 32'(bus.p0_err), 32'd0);

    // Port 0 read addr 5.
    next_cycle();
    p0_drive(1'b0, 32'd5, '0);
    @(negedge clk);
    chk("rd5_p0_gnt", 32'(bus.p0_gnt), 32'd1);
    chk("rd5_mem_rd", 32'(bus.mem_read), 32'd1);
    chk("wr_no_rvalid", 32'(bus.p0_rvalid), 32'd0);

    next_cycle();
    idle_ports();
    @(negedge clk);
    chk("rd5_p0_rvalid", 32'(bus.p0_rvalid), 32'd1);
    chk("rd5_p0_rdata", bus.p0_rdata, 32'hDEAD_BEEF);
    chk("rd5_p1_rvalid", 32'(bus.p1_rvalid), 32'd0);
    chk("rd5_p1_rdata", bus.p1_rdata, 32'd0);

    // Starvation: p0 reads addr 1 continuously, p1 read addr 7 raised at cycle 0.
    next_cycle();
    p0_drive(1'b0, 32'd1, '0);
    p1_drive(1'b0, 32'd7, '0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stv_p1_gnt_c%0d", k), 32'(bus.p1_gnt), (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("stv_p0_gnt_c%0d", k), 32'(bus.p0_gnt), (k == 4) ? 32'd0 : 32'd1);
      if (k >= 1) begin
        chk($sformatf("stv_p0_rvalid_c%0d", k), 32'(bus.p0_rvalid), 32'd1);
        chk($sformatf("stv_p0_rdata_c%0d", k), bus.p0_rdata, 32'h11);
      end
      if (k == 4) chk("stv_mem_addr", bus.mem_addr, 32'd7);
      next_cycle();
    end
    bus.p1_req = 1'b0;
    @(negedge clk);
    chk("stv_p1_rvalid", 32'(bus.p1_rvalid), 32'd1);
    chk("stv_p1_rdata", bus.p1_rdata, 32'hA000_0007);
    chk("stv_p0_rvalid_c5", 32'(bus.p0_rvalid), 32'd0);
    chk("stv_p0_rdata_c5", bus.p0_rdata, 32'd0);
    chk("stv_p0_gnt_c5", 32'(bus.p0_gnt), 32'd1);
    next_cycle();
    idle_ports();
    next_cycle();

    // Interleaved reads p0 addr1, p1 addr2, p0 addr3.
    p0_drive(1'b0, 32'd1, '0);
    @(negedge clk);
    chk("il_p0_gnt1", 32'(bus.p0_gnt), 32'd1);
    next_cycle();
    idle_ports();
    p1_drive(1'b0, 32'd2, '0);
    @(negedge clk);
    chk("il_p1_gnt", 32'(bus.p1_gnt), 32'd1);
    chk("il_p0_rvalid1", 32'(bus.p0_rvalid), 32'd1);
    chk("il_p0_rdata1", bus.p0_rdata, 32'h11);
    chk("il_p1_rvalid1", 32'(bus.p1_rvalid), 32'd0);
    next_cycle();
    idle_ports();
    p0_drive(1'b0, 32'd3, '0);
    @(negedge clk);
    chk("il_p0_gnt3", 32'(bus.p0_gnt), 32'd1);
    chk("il_p1_rvalid2", 32'(bus.p1_rvalid), 32'd1);
    chk("il_p1_rdata2", bus.p1_rdata, 32'h22);
    chk("il_p0_rvalid2", 32'(bus.p0_rvalid), 32'd0);
    chk("il_p0_rdata2", bus.p0_rdata, 32'd0);
    next_cycle();
    idle_ports();
    @(negedge clk);
    chk("il_p0_rvalid3", 32'(bus.p0_rvalid), 32'd1);
    chk("il_p0_rdata3", bus.p0_rdata, 32'h33);
    chk("il_p1_rvalid3", 32'(bus.p1_rvalid), 32'd0);

    // Out-of-range write and read on port 1.
    next_cycle();
    p1_drive(1'b1, 32'h400, 32'h1234_5678);
    @(negedge clk);
    chk("oor_wr_gnt", 32'(bus.p1_gnt), 32'd1);
    chk("oor_wr_mem_wr", 32'(bus.mem_write), 32'd0);
    chk("oor_wr_err", 32'(bus.p1_err), 32'd1);
    chk("oor_wr_p0_err", 32'(bus.p0_err), 32'd0);
    next_cycle();
    p1_drive(1'b0, 32'h400, '0);
    @(negedge clk);
    chk("oor_rd_gnt", 32'(bus.p1_gnt), 32'd1);
    chk("oor_rd_mem_rd", 32'(bus.mem_read), 32'd0);
    chk("oor_rd_err_gnt", 32'(bus.p1_err), 32'd0);
    next_cycle();
    idle_ports();
    p0_drive(1'b0, 32'd0, '0);
    @(negedge clk);
    chk("oor_rd_rvalid", 32'(bus.p1_rvalid), 32'd1);
    chk("oor_rd_err", 32'(bus.p1_err), 32'd1);
    chk("oor_rd_rdata", bus.p1_rdata, 32'd0);
    chk("oor_mem0", mem[0], 32'hA000_0000);
    next_cycle();
    idle_ports();
    @(negedge clk);
    chk("oor_rd0_rdata", bus.p0_rdata, 32'hA000_0000);
    chk("oor_rd0_err", 32'(bus.p0_err), 32'd0);

    // Reset in the cycle after a read grant.
    next_cycle();
    p0_drive(1'b0, 32'd5, '0);
    @(negedge clk);
    chk("rmr_p0_gnt", 32'(bus.p0_gnt), 32'd1);
    next_cycle();
    rst = 1'b1;
    p1_drive(1'b0, 32'd9, '0);
    @(negedge clk);
    chk("rmr_p0_rvalid", 32'(bus.p0_rvalid), 32'd0);
    chk("rmr_p0_gnt_rst", 32'(bus.p0_gnt), 32'd0);
    chk("rmr_p1_gnt_rst", 32'(bus.p1_gnt), 32'd0);
    next_cycle();
    rst = 1'b0;
    idle_ports();
    @(negedge clk);
    chk("rmr_p0_rvalid_after", 32'(bus.p0_rvalid), 32'd0);
    chk("rmr_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the pipeline MEM stage (port 0) and the debug/loader port (port 1). Port 0 has fixed priority, but an age counter bounds port 1 starvation. The block drives the memory's read/write controls, address and write data. It also routes the memory's one-cycle-latency read data back to the requester that issued the read. It sits between the EX/MEM pipeline register, the debug interface and the data memory.

## Interface
Parameters:
- ADDR_W, 10, number of implemented word-address bits; the memory holds 2^ADDR_W words.
- MAX_WAIT, 4, consecutive denied cycles after which port 1 is forced through; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- p0_req  in  1  port 0 access request, held until granted.
- p0_we  in  1  port 0 access type: 1 = write, 0 = read.
- p0_addr  in  32  port 0 word address.
- p0_wdata  in  32  port 0 write data.
- p0_gnt  out  1  port 0 access accepted this cycle; the pipeline stalls while p0_req=1 and p0_gnt=0.
- p0_rvalid  out  1  port 0 read data valid.
- p0_rdata  out  32  port 0 read data.
- p0_err  out  1  port 0 out-of-range flag, qualified by p0_rvalid or by a write acceptance.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same as port 0, for port 1.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; registered in the memory and valid the cycle after mem_read=1.

## Operation
- Grant logic is combinational from the requests and the registered state:
  - force = p1_req && (wait_cnt == MAX_WAIT).
  - p1_gnt = !rst && p1_req && (force || !p0_req).
  - p0_gnt = !rst && p0_req && !p1_gnt.
  - At most one grant per cycle.
- wait_cnt (4 bits):
  - Cleared when rst=1, p1_req=0, or p1_gnt=1.
  - Otherwise increments, saturating at MAX_WAIT.
- Memory muxing:
  - mem_addr and mem_wdata come from the granted port, or from port 0 when nothing is granted.
  - mem_write = gnt && we && in_range.
  - mem_read = gnt && !we && in_range.
  - in_range means address bits [31:ADDR_W] are all zero.
- Out-of-range access:
  - Still granted, but the memory is not touched.
  - Write: p*_err=1 in the grant cycle.
  - Read: the next cycle gives rvalid=1, err=1, rdata=0.
- Read return:
  - Registered rd_pend, rd_port and rd_oor capture the granted read.
  - The next cycle the owning port sees rvalid=1 and rdata = mem_rdata, or 0 if rd_oor.
  - The non-owning port sees rdata=0 and rvalid=0. The memory's Z output is never forwarded.
- Writes produce no rvalid.

## Timing
- Reset values:
  - gnt=0, rvalid=0, err=0, rdata=0 on both ports.
  - mem_read=0, mem_write=0.
  - wait_cnt=0, rd_pend=0.
- Grant latency: 0 cycles; the grant is in the request cycle when arbitration is won.
- Write: the memory captures it on the clock edge ending the grant cycle.
- Read latency: exactly 1 cycle from grant to rvalid.
- Back-to-back reads: one per cycle total across both ports. Alternating ports return in issue order, with no bubbles and no misrouting.
- Starvation bound: with p0_req held high, p1 is granted within MAX_WAIT+1 cycles of raising p1_req. Port 0 is denied for that single cycle only.
- Simultaneous requests with wait_cnt < MAX_WAIT: port 0 wins.
- Reset mid-operation: rst in the cycle after a read grant suppresses that rvalid. Any grant in a rst cycle is blocked.

## Test plan
- Reset: hold rst 2 cycles with both req=1 -> both gnt=0, mem_read=0, mem_write=0, rvalid=0. After release, p0_gnt=1 in the same cycle.
- Write/read port 0: p0 write addr 5 data 0xDEADBEEF, then read addr 5 -> gnt in each request cycle; p0_rvalid=1 with rdata 0xDEADBEEF one cycle after the read grant; p1_rvalid=0.
- Starvation: p0_req held high with reads, p1 read at addr 7 raised at cycle 0, MAX_WAIT=4 -> p1_gnt first at cycle 4, p0_gnt=0 at cycle 4 only, p1_rvalid at cycle 5.
- Interleaved returns: alternate grants p0 read addr 1 (0x11), p1 read addr 2 (0x22), p0 read addr 3 (0x33) -> rvalid alternates p0/p1/p0 with matching data on consecutive cycles.
- Out of range (ADDR_W=10): p1 write addr 0x400, then read 0x400 -> mem_write=0, p1_err=1 on the write; the read returns rvalid=1, err=1, rdata=0; memory word 0 unchanged.
- Reset mid-read: p0 read granted, rst asserted the next cycle -> p0_rvalid stays 0 and wait_cnt=0 after reset.
